// File: rtl/reg_read_arbiter.sv
// rtl/reg_read_arbiter.sv - round-robin arbiter sharing one register-bank read port among 4 clients
module reg_read_arbiter #(
    parameter int AW     = 5,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      req,
    input  logic [4*AW-1:0] req_addr,
    output logic [3:0]      ack,
    output logic [DW-1:0]   rdata,
    output logic [1:0]      mux_sel,
    output logic            bank_rd_en,
    output logic [AW-1:0]   bank_rd_addr,
    input  logic [DW-1:0]   bank_rd_data,
    output logic            busy
);

    logic [3:0]              outstanding;
    logic [1:0]              ptr;
    logic [3:0]              elig;
    logic                    grant_vld;
    logic [1:0]              grant_idx;
    logic [3:0]              grant_oh;
    logic [AW-1:0]           grant_addr;
    logic [RD_LAT-1:0]       pipe_vld;
    logic [RD_LAT-1:0][1:0]  pipe_id;

    // Scan downwards so the last hit, i.e. the one closest to ptr, wins.
    always_comb begin
        elig      = req & ~outstanding;
        grant_vld = |elig;
        grant_idx = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (elig[ptr + 2'(k)]) begin
                grant_idx = ptr + 2'(k);
            end
        end
        grant_oh   = 4'b0001 << grant_idx;
        grant_addr = req_addr[int'(grant_idx)*AW +: AW];
    end

    // The pipe tail lines up with bank_rd_data, so the return path stays combinational.
    always_comb begin
        ack   = 4'b0000;
        rdata = '0;
        if (pipe_vld[RD_LAT-1]) begin
            ack   = 4'b0001 << pipe_id[RD_LAT-1];
            rdata = bank_rd_data;
        end
    end

    assign busy = |outstanding;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= 2'd0;
            outstanding  <= 4'b0000;
            bank_rd_en   <= 1'b0;
            bank_rd_addr <= '0;
            mux_sel      <= 2'd0;
            pipe_vld     <= '0;
            pipe_id      <= '0;
        end else begin
            if (grant_vld) begin
                bank_rd_en   <= 1'b1;
                bank_rd_addr <= grant_addr;
                mux_sel      <= grant_idx;
                ptr          <= grant_idx + 2'd1;
            end else begin
                bank_rd_en   <= 1'b0;
            end

            // A grant never targets an id being acked: outstanding ids are not eligible.
            outstanding <= (outstanding & ~ack) | (grant_vld ? grant_oh : 4'b0000);

            pipe_vld[0] <= bank_rd_en;
            pipe_id[0]  <= mux_sel;
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                pipe_id[k]  <= pipe_id[k-1];
            end
        end
    end

endmodule
